video_timing_gen: RTL and testbench

Parametrised raster timing generator for the VGA display path, driven by the pixel clock. Horizontal and vertical counters run over a fully configurable frame. All outputs are registered and mutually aligned: sync, data-enable, position, line/frame strobes and a frame counter. Adds pixel clock-enable, programmable sync polarity and a synchronous restart for re-alignment; feeds the pixel/pattern generators and the VGA pins.

---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/vtg_axis_counter.sv | 39 +++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold values 0..v-1.
    function automatic int unsigned vtg_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while (r < 31 && (32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// Wrapping position counter for one raster axis with increment, clear and wrap-out.
module vtg_axis_counter #(
    parameter int unsigned Width = 10,
    parameter int unsigned Max   = 799
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o,
    output logic             wrap_o
);

    logic [Width-1:0] cnt_d, cnt_q;
    logic             at_max;

    assign at_max = (cnt_q == Width'(Max));
    assign wrap_o = inc_i & at_max;
    assign cnt_o  = cnt_q;

    // Clear wins over increment so a restart also cancels a pending wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters plus a registered output stage that lags them by one
// ce-qualified edge, so every output describes the same pixel.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FCNT_W   = 8
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              restart,
    output logic [CNT_W-1:0]  h_pos,
    output logic [CNT_W-1:0]  v_pos,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              sol,
    output logic              sof,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (vtg_clog2(H_TOTAL) > CNT_W || vtg_clog2(V_TOTAL) > CNT_W) begin : g_cnt_w_check
        $error("CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
    end

    logic [CNT_W-1:0] hc, vc;
    logic             h_wrap, v_wrap;

    vtg_axis_counter #(
        .Width (CNT_W),
        .Max   (H_TOTAL - 1)
    ) u_h_cnt (
        .clk_i  (pixel_clk),
        .rst_ni (reset_n),
        .inc_i  (ce),
        .clr_i  (restart),
        .cnt_o  (hc),
        .wrap_o (h_wrap)
    );

    vtg_axis_counter #(
        .Width (CNT_W),
        .Max   (V_TOTAL - 1)
    ) u_v_cnt (
        .clk_i  (pixel_clk),
        .rst_ni (reset_n),
        .inc_i  (h_wrap),
        .clr_i  (restart),
        .cnt_o  (vc),
        .wrap_o (v_wrap)
    );

    logic h_act, v_act, h_in_sync, v_in_sync;

    assign h_act     = 32'(hc) < H_ACTIVE;
    assign v_act     = 32'(vc) < V_ACTIVE;
    assign h_in_sync = (32'(hc) >= H_ACTIVE + H_FP) && (32'(hc) < H_ACTIVE + H_FP + H_SYNC);
    assign v_in_sync = (32'(vc) >= V_ACTIVE + V_FP) && (32'(vc) < V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]  h_pos_d, h_pos_q, v_pos_d, v_pos_q;
    logic              de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q;
    logic              sol_d, sol_q, sof_d, sof_q;
    logic [FCNT_W-1:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        h_pos_d     = h_pos_q;
        v_pos_d     = v_pos_q;
        de_d        = de_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        sol_d       = 1'b0;
        sof_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (ce) begin
            h_pos_d = hc;
            v_pos_d = vc;
            de_d    = h_act & v_act;
            hsync_d = h_in_sync ? HS_POL : ~HS_POL;
            vsync_d = v_in_sync ? VS_POL : ~VS_POL;
            sol_d   = (hc == '0);
            sof_d   = (hc == '0) && (vc == '0);
        end
        // Counts on the edge that emits the last pixel of a frame; restart suppresses it.
        if (v_wrap && !restart) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_pos_q     <= '0;
            v_pos_q     <= '0;
            de_q        <= 1'b0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            h_pos_q     <= h_pos_d;
            v_pos_q     <= v_pos_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sol_q       <= sol_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign h_pos     = h_pos_q;
    assign v_pos     = v_pos_q;
    assign de        = de_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign sol       = sol_q;
    assign sof       = sof_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster, with an inverted-polarity twin.
module tb_video_timing_gen;

    localparam int unsigned CW = 4;
    localparam int unsigned FW = 8;

    logic          pixel_clk = 1'b0;
    logic          reset_n   = 1'b0;
    logic          ce        = 1'b1;
    logic          restart   = 1'b0;

    logic [CW-1:0] h_pos, v_pos, h_pos_p, v_pos_p;
    logic          de, hsync, vsync, sol, sof;
    logic          de_p, hsync_p, vsync_p, sol_p, sof_p;
    logic [FW-1:0] frame_cnt, frame_cnt_p;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0), .CNT_W (CW), .FCNT_W (FW)
    ) u_dut (
        .pixel_clk (pixel_clk), .reset_n (reset_n), .ce (ce), .restart (restart),
        .h_pos (h_pos), .v_pos (v_pos), .de (de), .hsync (hsync), .vsync (vsync),
        .sol (sol), .sof (sof), .frame_cnt (frame_cnt)
    );

    video_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_W (CW), .FCNT_W (FW)
    ) u_dut_pol (
        .pixel_clk (pixel_clk), .reset_n (reset_n), .ce (ce), .restart (restart),
        .h_pos (h_pos_p), .v_pos (v_pos_p), .de (de_p), .hsync (hsync_p), .vsync (vsync_p),
        .sol (sol_p), .sof (sof_p), .frame_cnt (frame_cnt_p)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_h_pos"}, 32'(h_pos), 0);
        check_eq({tag, "_v_pos"}, 32'(v_pos), 0);
        check_eq({tag, "_de"}, 32'(de), 0);
        check_eq({tag, "_hsync"}, 32'(hsync), 1);
        check_eq({tag, "_vsync"}, 32'(vsync), 1);
        check_eq({tag, "_sol"}, 32'(sol), 0);
        check_eq({tag, "_sof"}, 32'(sof), 0);
        check_eq({tag, "_frame"}, 32'(frame_cnt), 0);
        check_eq({tag, "_hsync_pol"}, 32'(hsync_p), 0);
        check_eq({tag, "_vsync_pol"}, 32'(vsync_p), 0);
    endtask

    // One edge with the given ce/restart, then sample at the falling edge.
    task automatic step(input logic ce_v, input logic restart_v);
        ce      = ce_v;
        restart = restart_v;
        @(negedge pixel_clk);
    endtask

    initial begin
        int p, h, v, nxt;
        int n_sof, first_sof, last_sof, n_sol, last_sol;
        n_sof = 0; first_sof = 0; last_sof = 0; n_sol = 0; last_sol = 0;

        #12;
        check_reset_vals("rst");
        @(negedge pixel_clk);
        reset_n = 1'b1;

        // Three frames with ce high; full per-pixel check on the first frame.
        for (int k = 1; k <= 384; k++) begin
            step(1'b1, 1'b0);
            p = (k - 1) % 128;
            h = p % 16;
            v = p / 16;
            if (k <= 128) begin
                check_eq("h_pos", 32'(h_pos), h);
                check_eq("v_pos", 32'(v_pos), v);
                check_eq("de", 32'(de), (h < 8 && v < 4) ? 1 : 0);
                check_eq("hsync", 32'(hsync), (h >= 10 && h <= 12) ? 0 : 1);
                check_eq("vsync", 32'(vsync), (v >= 5 && v <= 6) ? 0 : 1);
                check_eq("hsync_pol", 32'(hsync_p), (h >= 10 && h <= 12) ? 1 : 0);
                check_eq("vsync_pol", 32'(vsync_p), (v >= 5 && v <= 6) ? 1 : 0);
                check_eq("sof", 32'(sof), (p == 0) ? 1 : 0);
            end
            check_eq("sol", 32'(sol), (h == 0) ? 1 : 0);
            if (sof) begin
                n_sof++;
                if (n_sof == 1) first_sof = k;
                else check_eq("sof_spacing", k - last_sof, 128);
                last_sof = k;
            end
            if (sol) begin
                n_sol++;
                if (n_sol > 1) check_eq("sol_spacing", k - last_sol, 16);
                last_sol = k;
            end
        end
        check_eq("frame_cnt_3", 32'(frame_cnt), 3);
        check_eq("sof_count", n_sof, 3);
        check_eq("sof_first", first_sof, 1);
        check_eq("sol_count", n_sol, 24);

        // ce alternating: outputs advance every other edge, strobes stay one cycle.
        nxt = 0;
        for (int j = 0; j < 32; j++) begin
            step((j % 2) == 0, 1'b0);
            if ((j % 2) == 0) begin
                check_eq("ce_h_pos", 32'(h_pos), nxt % 16);
                check_eq("ce_v_pos", 32'(v_pos), (nxt / 16) % 8);
                check_eq("ce_sol", 32'(sol), (nxt % 16 == 0) ? 1 : 0);
                check_eq("ce_sof", 32'(sof), (nxt == 0) ? 1 : 0);
                nxt++;
            end else begin
                check_eq("ce_hold_h_pos", 32'(h_pos), (nxt - 1) % 16);
                check_eq("ce_sol_clr", 32'(sol), 0);
                check_eq("ce_sof_clr", 32'(sof), 0);
            end
        end
        check_eq("ce_frame", 32'(frame_cnt), 3);

        // Advance to (5,2) then restart with ce low.
        while (nxt <= 37) begin
            step(1'b1, 1'b0);
            nxt++;
        end
        check_eq("pre_rs_h_pos", 32'(h_pos), 5);
        check_eq("pre_rs_v_pos", 32'(v_pos), 2);
        step(1'b0, 1'b1);
        check_eq("rs_hold_h_pos", 32'(h_pos), 5);
        check_eq("rs_hold_v_pos", 32'(v_pos), 2);
        check_eq("rs_hold_sof", 32'(sof), 0);
        step(1'b1, 1'b0);
        check_eq("rs_h_pos", 32'(h_pos), 0);
        check_eq("rs_v_pos", 32'(v_pos), 0);
        check_eq("rs_sol", 32'(sol), 1);
        check_eq("rs_sof", 32'(sof), 1);
        check_eq("rs_frame", 32'(frame_cnt), 3);
        step(1'b1, 1'b0);
        check_eq("rs_next_h_pos", 32'(h_pos), 1);
        check_eq("rs_next_sof", 32'(sof), 0);

        // Move to h_pos = 9, then pulse reset between clock edges.
        for (int j = 0; j < 8; j++) step(1'b1, 1'b0);
        check_eq("pre_rst_h_pos", 32'(h_pos), 9);
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #1;
        reset_n = 1'b1;
        @(negedge pixel_clk);
        check_eq("post_rst_h_pos", 32'(h_pos), 0);
        check_eq("post_rst_v_pos", 32'(v_pos), 0);
        check_eq("post_rst_sol", 32'(sol), 1);
        check_eq("post_rst_sof", 32'(sof), 1);
        check_eq("post_rst_de", 32'(de), 1);
        step(1'b1, 1'b0);
        check_eq("post_rst_next_h_pos", 32'(h_pos), 1);
        check_eq("post_rst_next_sof", 32'(sof), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
